div_seq: RTL
============

# div_seq

Multi-cycle sequencer for the execute-stage DIV/DIVU path. It accepts a divide request from the E stage and latches the operands. It runs a 32-iteration restoring division and holds the pipeline through `stall_div`. On completion it delivers `{remainder, quotient}` as a 64-bit word for the HI/LO write in M.

## Interface
Parameters:
- `WIDTH`, default 32. Operand width. Iteration count equals `WIDTH`.

Ports:
- `clk`, in, 1. Single clock, rising edge.
- `rst`, in, 1. Reset is synchronous and active-low: `rst`=0 at a rising edge resets the block.
- `start`, in, 1. E-stage instruction is DIV/DIVU.
- `signed_div`, in, 1. 1 = DIV (signed), 0 = DIVU. Sampled with `start`.
- `annul`, in, 1. Flush of the E-stage instruction.
- `dividend`, in, WIDTH. Forwarded rs value. Sampled with `start`.
- `divisor`, in, WIDTH. Forwarded rt value. Sampled with `start`.
- `stall_div`, out, 1. Holds F/D/E. Feeds the hazard unit.
- `busy`, out, 1. State is not IDLE.
- `done`, out, 1. One-cycle pulse; `result` is valid.
- `result`, out, 2*WIDTH. `{remainder[63:32], quotient[31:0]}`; `[63:32]`→HI, `[31:0]`→LO.

## Operation
States: IDLE, PREP, CALC, FIXUP, DONE.

- **IDLE**
  - `start`=1 and `annul`=0: latch operands and `signed_div`, go to PREP.
  - Otherwise stay in IDLE.
- **PREP**
  - Signed mode: take absolute values; record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Clear the partial remainder and the 6-bit counter.
  - Divisor = 0: load quotient = all-ones and remainder = original dividend (no sign fix-up), then go to DONE.
  - Divisor ≠ 0: go to CALC.
- **CALC**, one quotient bit per cycle, MSB first:
  - `{rem, quo}` shifts left by 1.
  - If `rem` ≥ `|divisor|`: `rem` -= `|divisor|` and `quo[0]`=1.
  - `rem` carries WIDTH+1 bits so the compare never overflows.
  - The counter increments each cycle; after iteration 32 (counter = 31 on the exit edge) go to FIXUP.
- **FIXUP**
  - Negate the quotient if `neg_q`; negate the remainder if `neg_r` (two's complement, modulo 2^32).
  - Write `result`, then go to DONE.
- **DONE**
  - `done`=1 and `stall_div`=0, so the pipeline advances and the DIV leaves E this cycle.
  - `start` is ignored.
  - Go to IDLE next cycle.

Outputs and arithmetic rules:
- `stall_div` = (IDLE & `start` & ~`annul`) | PREP | CALC | FIXUP. It is combinational from `start`.
- `result` holds its value from FIXUP (or PREP for divide-by-zero) until the next FIXUP or zero-detect. A later `start` does not change it until then.
- Unsigned mode skips all sign handling.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- `annul`=1 in any state sends the block to IDLE next cycle with no `done` pulse and `result` unchanged. `annul` has priority over `start` and over DONE.

## Timing
- Reset (`rst`=0): state IDLE, counter 0, `result`=0, `stall_div`=0, `busy`=0, `done`=0.
- Reset mid-operation aborts with the same values; no `done` pulse.
- Normal division, with cycle 0 = the accept edge cycle (IDLE, `start`=1):
  - PREP: cycle 1.
  - CALC: cycles 2–33.
  - FIXUP: cycle 34.
  - DONE: cycle 35, with `done`=1.
  - `stall_div`=1 for cycles 0–34 (35 cycles).
- Divide-by-zero: PREP at cycle 1, DONE at cycle 2; `stall_div`=1 for cycles 0–1.
- Back-to-back DIVs: the second `start` is accepted in IDLE on cycle 36, the earliest point. There is no combinational path from `done` to acceptance.
- `start` held high in DONE does not restart the same instruction.
- `busy`=1 from cycle 1 through DONE inclusive.

## Test plan
- Unsigned 100 / 7 (`start` at cycle 0) → `done` at cycle 35, `result`=0x00000002_0000000E; `stall_div` high exactly cycles 0–34.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → `result`=0xFFFFFFFF_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → `result`=0x00000000_80000000. Unsigned 5 / 0 → `done` at cycle 2, `result`=0x00000005_FFFFFFFF.
- `annul` at cycle 10 of a division → IDLE at cycle 11, no `done`, `result` keeps its prior value, `stall_div`=0 from cycle 11.
- Back-to-back: 100/7 then 9/3 with `start` held → second `done` at cycle 71 with `result`=0x00000000_00000003. `rst`=0 at cycle 20 of a division → all outputs 0 next cycle, no `done`.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for the execute-stage DIV/DIVU path.
// Latches a divide request, runs a WIDTH-iteration restoring division and
// holds F/D/E through stall_div; delivers {remainder, quotient} for HI/LO.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   start      in   E-stage instruction is DIV/DIVU
//   signed_div in   1 = DIV (signed), 0 = DIVU; sampled with start
//   annul      in   flush of the E-stage instruction (highest priority)
//   dividend   in   rs value, sampled with start
//   divisor    in   rt value, sampled with start
//   stall_div  out  holds F/D/E (combinational from start in IDLE)
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse, result valid
//   result     out  {remainder, quotient}; upper half -> HI, lower half -> LO
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               stall_div,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               sgn, neg_q, neg_r;
  logic [WIDTH-1:0]   dvd_raw, dvs_raw, dvs_abs;
  logic [WIDTH-1:0]   rem, quo;
  logic [WIDTH:0]     rem_sh, diff;
  logic               ge;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg2c(v) : v;
  endfunction

  // Shift {rem, quo} left by one; the extra bit keeps the compare exact.
  // rem < |divisor| before the shift, so when rem_sh >= |divisor| the
  // difference fits in WIDTH bits and the borrow bit is clear.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_abs};
  assign ge     = ~diff[WIDTH];

  always_comb begin
    nxt       = state;
    accept    = (state == IDLE) && start && !annul;
    stall_div = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:  begin
        stall_div = accept;
        if (accept) nxt = PREP;
      end
      PREP:  begin
        stall_div = 1'b1;
        nxt       = (dvs_raw == '0) ? DONE : CALC;
      end
      CALC:  begin
        stall_div = 1'b1;
        if (cnt == LAST) nxt = FIXUP;
      end
      FIXUP: begin
        stall_div = 1'b1;
        nxt       = DONE;
      end
      DONE:  begin
        done = !annul;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (annul) nxt = IDLE;
  end

  // Control: state, iteration counter and the architecturally visible result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= nxt;
      case (state)
        PREP: begin
          cnt <= '0;
          if (!annul && dvs_raw == '0)
            result <= {dvd_raw, {WIDTH{1'b1}}};
        end
        CALC: cnt <= cnt + CNT_W'(1);
        FIXUP: begin
          if (!annul)
            result <= {neg_r ? neg2c(rem) : rem, neg_q ? neg2c(quo) : quo};
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand capture, sign strip and one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_raw <= dividend;
      dvs_raw <= divisor;
      sgn     <= signed_div;
    end
    case (state)
      PREP: begin
        rem     <= '0;
        quo     <= sgn ? abs_val(dvd_raw) : dvd_raw;
        dvs_abs <= sgn ? abs_val(dvs_raw) : dvs_raw;
        neg_q   <= sgn & (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1]);
        neg_r   <= sgn & dvd_raw[WIDTH-1];
      end
      CALC: begin
        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
      end
      default: ;
    endcase
  end

endmodule
